// File: rtl/bicubic_pkg.sv
// ============================================================================
// bicubic_pkg : shared state encoding, geometry record and address constants
//               for the Bicubic upscaler sequencing controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package bicubic_pkg;

    localparam int IMG_W   = 100;
    localparam int ROM_AW  = 14;
    localparam int SRAM_AW = 12;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_STEP    = 3'd2,
        ST_FETCH   = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_WAIT_DP = 3'd5,
        ST_WRITE   = 3'd6,
        ST_FIN     = 3'd7
    } state_t;

    typedef struct packed {
        logic [6:0] h0;
        logic [6:0] v0;
        logic [4:0] sw;
        logic [4:0] sh;
        logic [5:0] tw;
        logic [5:0] th;
    } geom_t;

    // Source index base-1+k, clamped into the window [0, size-1].
    function automatic logic [4:0] clamp_src(input logic [5:0] base,
                                             input logic [1:0] k,
                                             input logic [4:0] size);
        logic [6:0] t;
        t = {1'b0, base} + {5'd0, k};
        if (t == 7'd0)
            return 5'd0;
        t = t - 7'd1;
        if (t > ({2'b00, size} - 7'd1))
            return size - 5'd1;
        return t[4:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/bicubic_dda.sv
// ============================================================================
// bicubic_dda : one axis of the division-free DDA; accumulates inc into rem
//               and carries into pos whenever rem reaches mod.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bicubic_dda (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       clear,
    input  logic [5:0] inc,
    input  logic [5:0] mod,
    output logic [5:0] pos,
    output logic [5:0] rem
);

    logic [6:0] sum;

    assign sum = {1'b0, rem} + {1'b0, inc};

    // inc < mod and rem < mod, so a single subtraction always suffices.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pos <= 6'd0;
            rem <= 6'd0;
        end else if (step) begin
            if (sum >= {1'b0, mod}) begin
                rem <= 6'(sum - {1'b0, mod});
                pos <= pos + 6'd1;
            end else begin
                rem <= sum[5:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bicubic_ctrl.sv
// ============================================================================
// bicubic_ctrl : raster walk over the target, 4x4 clamped neighbourhood fetch,
//                datapath handshake and ResultSRAM write-back.
//                Option macro BICUBIC_COL_REUSE_EN replays a stored window.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module bicubic_ctrl
    import bicubic_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [6:0]         H0,
    input  logic [6:0]         V0,
    input  logic [4:0]         SW,
    input  logic [4:0]         SH,
    input  logic [5:0]         TW,
    input  logic [5:0]         TH,
    output logic               rom_rd,
    output logic [ROM_AW-1:0]  rom_a,
    input  logic [7:0]         rom_q,
    output logic               px_valid,
    output logic [3:0]         px_idx,
    output logic [7:0]         px_data,
    output logic [5:0]         frac_x,
    output logic [5:0]         frac_y,
    output logic [5:0]         den_x,
    output logic [5:0]         den_y,
    input  logic               dp_valid,
    input  logic [7:0]         dp_pix,
    output logic               sram_wen,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [7:0]         sram_d,
    output logic               busy,
    output logic               cfg_err,
    output logic               DONE
);

    state_t            state, state_nx;
    geom_t             geom;
    logic [5:0]        tx, ty, ix, iy;
    logic [3:0]        cnt;
    logic [7:0]        res_q;
    logic              pxv_q;
    logic [3:0]        pxi_q;
    logic              row_end, last_px, bad_geom, reuse_hit, replay_busy;
    logic              x_step, x_clear, y_step, y_clear;
    logic [5:0]        inc_x, inc_y, mod_x, mod_y;
    logic [4:0]        src_col, src_row;
    logic [ROM_AW-1:0] row_abs;

    assign bad_geom = (TW <= {1'b0, SW}) || (TH <= {1'b0, SH});
    assign row_end  = (tx == geom.tw - 6'd1);
    assign last_px  = row_end && (ty == geom.th - 6'd1);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (start) state_nx = ST_LOAD;
            ST_LOAD:    state_nx = bad_geom ? ST_FIN : ST_STEP;
            ST_STEP:    state_nx = reuse_hit ? ST_WAIT_DP : ST_FETCH;
            ST_FETCH:   if (cnt == 4'd15) state_nx = ST_DRAIN;
            ST_DRAIN:   state_nx = ST_WAIT_DP;
            ST_WAIT_DP: if (dp_valid && !replay_busy) state_nx = ST_WRITE;
            ST_WRITE:   state_nx = last_px ? ST_FIN : ST_STEP;
            ST_FIN:     state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            geom    <= '0;
            tx      <= 6'd0;
            ty      <= 6'd0;
            cnt     <= 4'd0;
            res_q   <= 8'd0;
            den_x   <= 6'd0;
            den_y   <= 6'd0;
            cfg_err <= 1'b0;
            pxv_q   <= 1'b0;
            pxi_q   <= 4'd0;
        end else begin
            pxv_q <= rom_rd;
            pxi_q <= rom_rd ? cnt : 4'd0;
            case (state)
                ST_IDLE: if (start) cfg_err <= 1'b0;
                ST_LOAD: begin
                    geom  <= '{h0: H0, v0: V0, sw: SW, sh: SH, tw: TW, th: TH};
                    tx    <= 6'd0;
                    ty    <= 6'd0;
                    den_x <= TW - 6'd1;
                    den_y <= TH - 6'd1;
                    if (bad_geom) cfg_err <= 1'b1;
                end
                ST_STEP:    cnt <= 4'd0;
                ST_FETCH:   cnt <= cnt + 4'd1;
                ST_WAIT_DP: if (dp_valid) res_q <= dp_pix;
                ST_WRITE: begin
                    if (!last_px) begin
                        if (row_end) begin
                            tx <= 6'd0;
                            ty <= ty + 6'd1;
                        end else begin
                            tx <= tx + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // x restarts at every row; y advances only on row wrap.
    assign x_clear = (state == ST_LOAD) || (state == ST_WRITE && row_end);
    assign x_step  = (state == ST_WRITE) && !row_end;
    assign y_clear = (state == ST_LOAD);
    assign y_step  = (state == ST_WRITE) && row_end && !last_px;
    assign inc_x   = {1'b0, geom.sw} - 6'd1;
    assign inc_y   = {1'b0, geom.sh} - 6'd1;
    assign mod_x   = geom.tw - 6'd1;
    assign mod_y   = geom.th - 6'd1;

    bicubic_dda u_dda_x (
        .clk   (CLK),
        .rst   (RST),
        .step  (x_step),
        .clear (x_clear),
        .inc   (inc_x),
        .mod   (mod_x),
        .pos   (ix),
        .rem   (frac_x)
    );

    bicubic_dda u_dda_y (
        .clk   (CLK),
        .rst   (RST),
        .step  (y_step),
        .clear (y_clear),
        .inc   (inc_y),
        .mod   (mod_y),
        .pos   (iy),
        .rem   (frac_y)
    );

    assign src_col  = clamp_src(ix, cnt[1:0], geom.sw);
    assign src_row  = clamp_src(iy, cnt[3:2], geom.sh);
    assign row_abs  = ROM_AW'(geom.v0) + ROM_AW'(src_row);
    assign rom_rd   = (state == ST_FETCH);
    assign rom_a    = rom_rd ? (row_abs * ROM_AW'(IMG_W) + ROM_AW'(geom.h0) + ROM_AW'(src_col))
                             : '0;
    assign sram_wen = (state == ST_WRITE);
    assign sram_a   = sram_wen ? (SRAM_AW'(ty) * SRAM_AW'(geom.tw) + SRAM_AW'(tx)) : '0;
    assign sram_d   = sram_wen ? res_q : 8'd0;
    assign busy     = (state != ST_IDLE);
    assign DONE     = (state == ST_FIN);

`ifdef BICUBIC_COL_REUSE_EN
    logic [7:0] win [16];
    logic       replay;
    logic [3:0] rep_cnt;
    logic [5:0] prev_ix, prev_iy;
    logic       prev_ok;

    assign reuse_hit   = prev_ok && (ix == prev_ix) && (iy == prev_iy);
    assign replay_busy = replay;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) win[i] <= 8'd0;
            replay  <= 1'b0;
            rep_cnt <= 4'd0;
            prev_ix <= 6'd0;
            prev_iy <= 6'd0;
            prev_ok <= 1'b0;
        end else begin
            if (pxv_q) win[pxi_q] <= rom_q;
            if (state == ST_STEP) begin
                if (reuse_hit) begin
                    replay  <= 1'b1;
                    rep_cnt <= 4'd0;
                end else begin
                    prev_ix <= ix;
                    prev_iy <= iy;
                    prev_ok <= 1'b1;
                end
            end else if (replay) begin
                rep_cnt <= rep_cnt + 4'd1;
                if (rep_cnt == 4'd15) replay <= 1'b0;
            end
            if (state == ST_LOAD || (state == ST_WRITE && row_end)) prev_ok <= 1'b0;
        end
    end

    assign px_valid = pxv_q | replay;
    assign px_idx   = replay ? rep_cnt : pxi_q;
    assign px_data  = replay ? win[rep_cnt] : (pxv_q ? rom_q : 8'd0);
`else
    assign reuse_hit   = 1'b0;
    assign replay_busy = 1'b0;
    assign px_valid    = pxv_q;
    assign px_idx      = pxi_q;
    assign px_data     = pxv_q ? rom_q : 8'd0;
`endif

endmodule

`default_nettype wire

// File: doc/bicubic_ctrl.md
# bicubic_ctrl

Sequencing controller for the Bicubic upscaler. It latches the source-window origin/size and target size, walks every target pixel in raster order, and computes each pixel's integer source position and fractional phase with a division-free DDA. It fetches the clamped 4×4 source neighbourhood from ImgROM into the interpolation datapath, waits for the datapath result, writes it to ResultSRAM, and raises DONE at job end. It sits between the Bicubic top-level ports and the ImgROM / kernel datapath / ResultSRAM.

## Interface
- IMG_W, 100, ImgROM row pitch in pixels
- ROM_AW, 14, ImgROM address width
- SRAM_AW, 12, ResultSRAM address width
- CLK  in  1  clock; all logic is on the rising edge
- RST  in  1  reset, synchronous, active-high
- start  in  1  one-cycle job start; ignored unless in IDLE
- H0, V0  in  7 each  source window origin (column, row)
- SW, SH  in  5 each  source window width, height
- TW, TH  in  6 each  target width, height
- rom_rd  out  1  ROM read strobe
- rom_a  out  ROM_AW  ROM address
- rom_q  in  8  ROM data, valid 1 cycle after rom_rd
- px_valid  out  1  neighbourhood pixel valid to datapath
- px_idx  out  4  neighbourhood index, row*4+col, 0..15
- px_data  out  8  pixel value
- frac_x, frac_y  out  6 each  phase numerators
- den_x, den_y  out  6 each  phase denominators (TW-1, TH-1)
- dp_valid  in  1  datapath result valid
- dp_pix  in  8  datapath result
- sram_wen  out  1  ResultSRAM write strobe
- sram_a  out  SRAM_AW  write address
- sram_d  out  8  write data
- busy  out  1  high outside IDLE
- cfg_err  out  1  sticky; set when TW<=SW or TH<=SH; cleared by the next start
- DONE  out  1  one-cycle job-complete pulse

## Operation
- States: IDLE → LOAD → STEP → FETCH → DRAIN → WAIT_DP → WRITE → (STEP | FIN) → IDLE.
- LOAD: latch all geometry inputs. Clear tx, ty, ix, iy, rx, ry. If TW<=SW or TH<=SH, set cfg_err and go to FIN with no writes.
- DDA x-axis, per tx increment: rx += SW-1. If rx >= TW-1, then rx -= TW-1 and ix++. Because SW<TW, at most one carry occurs per step. At row start, rx=ix=0.
- DDA y-axis: the same rule, applied per ty using SH-1 and TH-1.
- frac_x=rx, frac_y=ry, den_x=TW-1, den_y=TH-1. These hold stable from STEP through WRITE.
- FETCH: 16 cycles, one rom_rd per cycle, in order r=0..3, c=0..3.
  - Source column = clamp(ix-1+c, 0, SW-1); source row = clamp(iy-1+r, 0, SH-1).
  - rom_a = (V0+row)*IMG_W + H0 + col, computed in ROM_AW bits without overflow.
- px_valid/px_idx/px_data lag rom_rd by exactly 1 cycle; the last pixel emerges in DRAIN.
- WAIT_DP: hold until dp_valid. dp_valid outside WAIT_DP is ignored.
- WRITE: sram_wen=1, sram_a = ty*TW + tx, sram_d = dp_pix captured in WAIT_DP.
- After WRITE: if tx=TW-1 and ty=TH-1, go to FIN; otherwise advance the DDA and go to STEP.
- FIN: DONE=1 for one cycle, then IDLE.

## Timing
- Reset values: every output is 0, cfg_err=0, state=IDLE.
- RST during a job aborts it within 1 cycle. No further rom_rd or sram_wen is issued, and no DONE is produced.
- start→first rom_rd: 2 cycles (LOAD, STEP).
- Per pixel with no stall: STEP 1 + FETCH 16 + DRAIN 1 + WAIT_DP ≥1 + WRITE 1 = 20 cycles minimum.
- WRITE of the last pixel → DONE on the next cycle.
- start held or repeated while busy has no effect.

## Configuration
- BICUBIC_COL_REUSE_EN defined: a 16-entry window register stores the fetched pixels.
  - If STEP finds the same ix and iy as the previous pixel in the same row, FETCH and DRAIN are skipped.
  - The stored 16 pixels are replayed on px_valid, one per cycle.
  - No rom_rd is issued for that pixel.
- BICUBIC_COL_REUSE_EN undefined: every pixel performs all 16 ROM reads.
- Output data is identical in both builds; only the rom_rd count differs.

## Structure
- Shared package bicubic_pkg holds:
  - the state enum;
  - IMG_W, ROM_AW, SRAM_AW;
  - the geometry struct {H0, V0, SW, SH, TW, TH}.
- One sub-module, bicubic_dda: a per-axis step/carry unit, instantiated twice (x and y). Its ports are step, clear, inc, mod, pos, rem.

## Test plan
- H0=10, V0=20, SW=4, SH=4, TW=7, TH=7, target (3,3):
  - DDA gives ix=1, rx=3, den_x=6;
  - first rom_a=2010, last rom_a=2313;
  - sram_a=24.
- SW=SH=2, TW=TH=3, target (0,0):
  - rows/cols -1 clamp to 0, so px_idx 0,1,4,5 all read address (V0)*100+H0;
  - exactly 9 sram_wen pulses, then DONE.
- TW=4, SW=4:
  - cfg_err=1;
  - DONE 2 cycles after start;
  - zero rom_rd and zero sram_wen.
- dp_valid delayed 5 cycles after DRAIN: no sram_wen until the cycle after dp_valid, and sram_d equals dp_pix.
- RST asserted on FETCH cycle 7: the next cycle has all outputs 0 and busy=0; a new start runs correctly.
- With BICUBIC_COL_REUSE_EN, for one target row with SW=4, TW=7: ix sequence is 0,0,1,1,2,2,3, giving 64 rom_rd versus 112 without the macro; SRAM contents are identical in both builds.
